// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks EX/MEM/WB occupants, drives forwarding selects, load-use stall and flush strobes.
// Latency: strobes and fwd_sel are combinational (zero cycles); scoreboard and counters update on the next clock edge.
// Backpressure: ext_stall freezes scoreboard and counters and forces every strobe low; fwd_sel keeps following the EX entry.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int NREAD    = 2,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ext_stall,
    input  logic                    id_valid,
    input  logic [NREAD*REG_AW-1:0] id_rs,
    input  logic [NREAD-1:0]        id_rs_used,
    input  logic                    id_wr_en,
    input  logic [REG_AW-1:0]       id_wr_idx,
    input  logic                    id_is_load,
    input  logic                    br_taken,
    output logic                    stall_if_id,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic                    ex_mem_flush,
    output logic [2*NREAD-1:0]      fwd_sel,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    // Branches resolving in MEM also kill the instruction moving EX->MEM.
    localparam bit BR_IN_MEM = (BR_STAGE == 3);

    // EX needs operand indices for forwarding; older stages only ever act as producers,
    // so they carry just the fields that decide whether and what they write.
    typedef struct packed {
        logic                    valid;
        logic                    wr_en;
        logic [REG_AW-1:0]       wr_idx;
        logic                    is_load;
        logic [NREAD*REG_AW-1:0] rs;
        logic [NREAD-1:0]        rs_used;
    } ex_ent_t;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_idx;
        logic              is_load;
    } mem_ent_t;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [REG_AW-1:0] wr_idx;
    } wb_ent_t;

    ex_ent_t          ex_q, ex_d;
    mem_ent_t         mem_q, mem_d;
    wb_ent_t          wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_wr, mem_wr, wb_wr;
    logic rs_hit;
    logic lu;

    // A stage is a producer only when it writes a register other than r0.
    always_comb begin
        ex_wr  = ex_q.valid  & ex_q.wr_en  & (ex_q.wr_idx  != '0);
        mem_wr = mem_q.valid & mem_q.wr_en & (mem_q.wr_idx != '0);
        wb_wr  = wb_q.valid  & wb_q.wr_en  & (wb_q.wr_idx  != '0);
    end

    // Load-use: ID reads the register a load in EX has not produced yet.
    always_comb begin
        rs_hit = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (id_rs_used[p] && (id_rs[p*REG_AW +: REG_AW] == ex_q.wr_idx)) begin
                rs_hit = 1'b1;
            end
        end
        lu = id_valid & ex_wr & ex_q.is_load & rs_hit;
    end

    // Strobe priority: freeze, then redirect, then load-use bubble.
    always_comb begin
        stall_if_id  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!ext_stall) begin
            if (br_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = BR_IN_MEM;
            end else if (lu) begin
                stall_if_id = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Per-port operand source for the EX instruction; the younger producer (MEM) wins,
    // except a load still in MEM, whose data does not exist yet.
    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (ex_q.valid && ex_q.rs_used[p]) begin
                if (mem_wr && !mem_q.is_load && (mem_q.wr_idx == ex_q.rs[p*REG_AW +: REG_AW])) begin
                    fwd_sel[2*p +: 2] = 2'd1;
                end else if (wb_wr && (wb_q.wr_idx == ex_q.rs[p*REG_AW +: REG_AW])) begin
                    fwd_sel[2*p +: 2] = 2'd2;
                end
            end
        end
    end

    // Scoreboard advance: shift occupants down, inserting bubbles where instructions are killed.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!ext_stall) begin
            wb_d.valid   = mem_q.valid;
            wb_d.wr_en   = mem_q.wr_en;
            wb_d.wr_idx  = mem_q.wr_idx;

            mem_d.valid   = ex_q.valid & ~(br_taken & BR_IN_MEM);
            mem_d.wr_en   = ex_q.wr_en;
            mem_d.wr_idx  = ex_q.wr_idx;
            mem_d.is_load = ex_q.is_load;

            ex_d.valid   = id_valid & ~br_taken & ~lu;
            ex_d.wr_en   = id_wr_en;
            ex_d.wr_idx  = id_wr_idx;
            ex_d.is_load = id_is_load;
            ex_d.rs      = id_rs;
            ex_d.rs_used = id_rs_used;
        end
    end

    // Saturating event counters; a flush outranks a coincident stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ext_stall) begin
            if (br_taken) begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
            end else if (lu) begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset empties the scoreboard so a held stall is forgotten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (branch in MEM / 16-bit counters, branch in EX / 2-bit counters)
// share one stimulus stream; an instruction-level pipeline model predicts every output each cycle.
// Directed instruction sequences come first, then randomized traffic with occasional freezes and resets.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_stall;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       id_wr_en;
    logic [4:0] id_wr_idx;
    logic       id_is_load;
    logic       br_taken;

    logic        o_st[2], o_ifid[2], o_idex[2], o_exmem[2];
    logic [3:0]  o_fwd[2];
    logic [15:0] o_sc[2], o_fc[2];
    logic [1:0]  sc1, fc1;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .NREAD(2), .BR_STAGE(3), .CNT_W(16)) u_mem (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_wr_en(id_wr_en), .id_wr_idx(id_wr_idx), .id_is_load(id_is_load),
        .br_taken(br_taken), .stall_if_id(o_st[0]), .if_id_flush(o_ifid[0]), .id_ex_flush(o_idex[0]),
        .ex_mem_flush(o_exmem[0]), .fwd_sel(o_fwd[0]), .stall_cnt(o_sc[0]), .flush_cnt(o_fc[0])
    );

    pipe_hazard_ctrl #(.REG_AW(5), .NREAD(2), .BR_STAGE(2), .CNT_W(2)) u_ex (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_wr_en(id_wr_en), .id_wr_idx(id_wr_idx), .id_is_load(id_is_load),
        .br_taken(br_taken), .stall_if_id(o_st[1]), .if_id_flush(o_ifid[1]), .id_ex_flush(o_idex[1]),
        .ex_mem_flush(o_exmem[1]), .fwd_sel(o_fwd[1]), .stall_cnt(sc1), .flush_cnt(fc1)
    );
    assign o_sc[1] = {14'd0, sc1};
    assign o_fc[1] = {14'd0, fc1};

    // ---------------- reference model: one instruction record per stage ----------------
    localparam int BRS[2]  = '{3, 2};
    localparam int CMAX[2] = '{65535, 3};

    // stage 0 = EX, 1 = MEM, 2 = WB
    bit mv  [2][3];
    bit mwe [2][3];
    bit mld [2][3];
    int midx[2][3];
    int mrs [2][3][2];
    bit mru [2][3][2];
    int msc [2];
    int mfc [2];

    function automatic bit producer(int i, int s);
        return mv[i][s] && mwe[i][s] && (midx[i][s] != 0);
    endfunction

    function automatic bit model_lu(int i);
        if (!id_valid || !producer(i, 0) || !mld[i][0]) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (id_rs_used[p] && (int'(id_rs[p*5 +: 5]) == midx[i][0])) return 1'b1;
        return 1'b0;
    endfunction

    // Source of EX operand p: nearest older stage that produced it, skipping a load still in MEM.
    function automatic int model_fwd(int i);
        int e, val;
        bit found;
        e = 0;
        for (int p = 0; p < 2; p++) begin
            val = 0;
            found = 1'b0;
            if (mv[i][0] && mru[i][0][p]) begin
                for (int s = 1; s <= 2; s++) begin
                    if (!found && producer(i, s) && (midx[i][s] == mrs[i][0][p]) && !(s == 1 && mld[i][s])) begin
                        val = s;
                        found = 1'b1;
                    end
                end
            end
            e = e | (val << (2 * p));
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) mv[i][s] = 1'b0;
            msc[i] = 0;
            mfc[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit lu;
        if (!rst) begin
            model_reset();
            return;
        end
        if (ext_stall) return;
        for (int i = 0; i < 2; i++) begin
            lu = model_lu(i);
            if (br_taken) mfc[i] = (mfc[i] + 1 > CMAX[i]) ? CMAX[i] : mfc[i] + 1;
            else if (lu)  msc[i] = (msc[i] + 1 > CMAX[i]) ? CMAX[i] : msc[i] + 1;
            for (int s = 2; s >= 1; s--) begin
                mv[i][s] = mv[i][s-1]; mwe[i][s] = mwe[i][s-1]; mld[i][s] = mld[i][s-1];
                midx[i][s] = midx[i][s-1];
                for (int p = 0; p < 2; p++) begin
                    mrs[i][s][p] = mrs[i][s-1][p];
                    mru[i][s][p] = mru[i][s-1][p];
                end
            end
            if (br_taken && BRS[i] == 3) mv[i][1] = 1'b0;
            mv[i][0]   = id_valid && !br_taken && !lu;
            mwe[i][0]  = id_wr_en;
            mld[i][0]  = id_is_load;
            midx[i][0] = int'(id_wr_idx);
            for (int p = 0; p < 2; p++) begin
                mrs[i][0][p] = int'(id_rs[p*5 +: 5]);
                mru[i][0][p] = id_rs_used[p];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, int act, int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        bit lu, fr, br;
        for (int i = 0; i < 2; i++) begin
            lu = model_lu(i);
            fr = ext_stall;
            br = br_taken;
            chk($sformatf("inst%0d stall_if_id", i), int'(o_st[i]), int'(!fr && !br && lu));
            chk($sformatf("inst%0d if_id_flush", i), int'(o_ifid[i]), int'(!fr && br));
            chk($sformatf("inst%0d id_ex_flush", i), int'(o_idex[i]), int'(!fr && (br || lu)));
            chk($sformatf("inst%0d ex_mem_flush", i), int'(o_exmem[i]), int'(!fr && br && BRS[i] == 3));
            chk($sformatf("inst%0d fwd_sel", i), int'(o_fwd[i]), model_fwd(i));
            chk($sformatf("inst%0d stall_cnt", i), int'(o_sc[i]), msc[i]);
            chk($sformatf("inst%0d flush_cnt", i), int'(o_fc[i]), mfc[i]);
        end
    endtask

    // Drive one ID presentation, then compare at the falling edge.
    task automatic put(bit v, int rs0, int rs1, bit [1:0] ru, bit we, int wd, bit ld, bit b, bit xs);
        id_valid   = v;
        id_rs      = {5'(rs1), 5'(rs0)};
        id_rs_used = ru;
        id_wr_en   = we;
        id_wr_idx  = 5'(wd);
        id_is_load = ld;
        br_taken   = b;
        ext_stall  = xs;
        if (!rst) model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic nop();
        put(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        model_reset();

        // reset held with a live ID instruction
        for (int k = 0; k < 3; k++) begin
            put(1, 3, 3, 2'b11, 1, 3, 1, 0, 0);
            chk("reset stall_if_id", int'(o_st[0]), 0);
            chk("reset fwd_sel", int'(o_fwd[0]), 0);
            chk("reset stall_cnt", int'(o_sc[0]), 0);
            adv();
        end
        rst = 1'b1;
        put(1, 3, 3, 2'b11, 1, 3, 1, 0, 0);
        chk("post-reset id_ex_flush", int'(o_idex[0]), 0);
        adv();
        nop();
        chk("post-reset stall_cnt", int'(o_sc[0]), 0);
        adv();
        repeat (3) begin nop(); adv(); end

        // back-to-back ALU: ADD r3,r1,r2 ; SUB r4,r3,r3
        put(1, 1, 2, 2'b11, 1, 3, 0, 0, 0); adv();
        put(1, 3, 3, 2'b11, 1, 4, 0, 0, 0); adv();
        nop();
        chk("b2b fwd_sel", int'(o_fwd[0]), 5);
        chk("b2b stall_if_id", int'(o_st[0]), 0);
        adv();
        repeat (3) begin nop(); adv(); end

        // gap of one: ADD r3 ; NOP ; OR r5,r3,r0
        put(1, 1, 2, 2'b11, 1, 3, 0, 0, 0); adv();
        nop(); adv();
        put(1, 3, 0, 2'b11, 1, 5, 0, 0, 0); adv();
        nop();
        chk("gap fwd_sel", int'(o_fwd[0]), 2);
        adv();
        repeat (3) begin nop(); adv(); end

        // load-use: LW r7,0(r1) ; ADD r8,r7,r1
        put(1, 1, 0, 2'b01, 1, 7, 1, 0, 0); adv();
        put(1, 7, 1, 2'b11, 1, 8, 0, 0, 0);
        chk("lu stall_if_id", int'(o_st[0]), 1);
        chk("lu id_ex_flush", int'(o_idex[0]), 1);
        chk("lu if_id_flush", int'(o_ifid[0]), 0);
        adv();
        put(1, 7, 1, 2'b11, 1, 8, 0, 0, 0);
        chk("lu released", int'(o_st[0]), 0);
        chk("lu stall_cnt", int'(o_sc[0]), 1);
        adv();
        nop();
        chk("lu fwd_sel", int'(o_fwd[0]), 2);
        adv();
        repeat (3) begin nop(); adv(); end

        // taken branch kills the instruction entering MEM only when it resolves in MEM
        put(1, 1, 2, 2'b11, 1, 3, 0, 0, 0); adv();
        put(1, 3, 3, 2'b11, 1, 6, 0, 1, 0);
        chk("br ex_mem_flush mem", int'(o_exmem[0]), 1);
        chk("br ex_mem_flush ex", int'(o_exmem[1]), 0);
        chk("br if_id_flush ex", int'(o_ifid[1]), 1);
        adv();
        put(1, 3, 0, 2'b11, 1, 9, 0, 0, 0);
        chk("br flush_cnt", int'(o_fc[0]), 1);
        adv();
        nop();
        chk("br killed producer", int'(o_fwd[0]), 0);
        chk("br surviving producer", int'(o_fwd[1]), 2);
        adv();
        repeat (3) begin nop(); adv(); end

        // freeze over a load-use with a redirect, then redirect beats load-use
        put(1, 1, 0, 2'b01, 1, 7, 1, 0, 0); adv();
        put(1, 7, 1, 2'b11, 1, 8, 0, 1, 1);
        chk("freeze stall_if_id", int'(o_st[0]), 0);
        chk("freeze if_id_flush", int'(o_ifid[0]), 0);
        chk("freeze id_ex_flush", int'(o_idex[0]), 0);
        chk("freeze ex_mem_flush", int'(o_exmem[0]), 0);
        adv();
        put(1, 7, 1, 2'b11, 1, 8, 0, 1, 0);
        chk("br+lu stall_if_id", int'(o_st[0]), 0);
        chk("br+lu id_ex_flush", int'(o_idex[0]), 1);
        adv();
        nop();
        chk("br+lu stall_cnt", int'(o_sc[0]), 1);
        chk("br+lu flush_cnt", int'(o_fc[0]), 2);
        adv();

        // five more load-use stalls saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            put(1, 1, 0, 2'b01, 1, 7, 1, 0, 0); adv();
            put(1, 7, 1, 2'b01, 1, 8, 0, 0, 0); adv();
            nop(); adv();
        end
        nop();
        chk("sat stall_cnt 2b", int'(o_sc[1]), 3);
        chk("sat stall_cnt 16b", int'(o_sc[0]), 6);
        adv();

        // reset while a stall is pending
        put(1, 1, 0, 2'b01, 1, 7, 1, 0, 0); adv();
        put(1, 7, 1, 2'b11, 1, 8, 0, 0, 0);
        chk("pre-reset stall", int'(o_st[0]), 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid-reset stall", int'(o_st[0]), 0);
        chk("mid-reset stall_cnt", int'(o_sc[0]), 0);
        adv();
        rst = 1'b1;
        put(1, 7, 1, 2'b11, 1, 8, 0, 0, 0);
        chk("re-present no stall", int'(o_st[0]), 0);
        adv();

        // randomized traffic over a small register window so hazards are frequent
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 399) != 0);
            put(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB datapath.
- Keeps a shadow scoreboard of the EX, MEM and WB stage occupants.
- Produces per-read-port forwarding selects, load-use stall, and per-stage flush strobes.
- These strobes drive the stall/flush pins of the existing pipeline registers, replacing today's unconnected pins.

Parameters:
REG_AW, 5, register-index width.
NREAD, 2, number of source-operand read ports.
BR_STAGE, 3, stage where branches resolve: 2=EX, 3=MEM. No other value is legal.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ext_stall  in  1  global freeze (e.g. memory wait); all stages hold
id_valid  in  1  ID stage holds a real instruction
id_rs  in  NREAD*REG_AW  source indices of the ID instruction; port p = bits [p*REG_AW +: REG_AW]
id_rs_used  in  NREAD  port p actually reads its register
id_wr_en  in  1  ID instruction writes a register
id_wr_idx  in  REG_AW  destination index
id_is_load  in  1  ID instruction is a load
br_taken  in  1  redirect from the BR_STAGE stage this cycle
stall_if_id  out  1  hold PC and IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX (bubble)
ex_mem_flush  out  1  clear EX/MEM; constant 0 when BR_STAGE=2
fwd_sel  out  2*NREAD  per EX-stage port: 0=regfile, 1=EX/MEM result, 2=MEM/WB result
stall_cnt  out  CNT_W  cycles with load-use stall
flush_cnt  out  CNT_W  taken redirects

Behaviour:
- Scoreboard entries: EX, MEM, WB. Each holds {valid, wr_en, wr_idx, is_load, rs[NREAD], rs_used[NREAD]}.
- An entry is a writer only if valid & wr_en & wr_idx != 0. Register 0 never causes a hazard and is never forwarded.
- Load-use hazard (lu) = id_valid & EX writer & EX.is_load & (some port p: id_rs_used[p] & id_rs[p]==EX.wr_idx).
- Priority per cycle:
  - ext_stall: all outputs except fwd_sel are 0; scoreboard and counters hold.
  - else br_taken: if_id_flush=1 and id_ex_flush=1. ex_mem_flush=1 iff BR_STAGE=3. stall_if_id=0. flush_cnt +1.
  - else lu: stall_if_id=1, id_ex_flush=1, stall_cnt +1.
  - else: all strobes 0.
- Scoreboard update on posedge when !ext_stall:
  - WB<=MEM.
  - MEM<=EX, except MEM.valid<=0 when br_taken and BR_STAGE=3.
  - EX<=ID fields with valid=id_valid, except EX.valid<=0 when br_taken or lu.
- fwd_sel is combinational from the EX entry, for each port p with EX.valid & rs_used[p]:
  - 1 if MEM writer, !MEM.is_load and MEM.wr_idx==rs[p];
  - else 2 if WB writer and WB.wr_idx==rs[p];
  - else 0.
  - Youngest producer wins.
  - MEM.is_load with a match cannot occur given the stall; if it does, select 2 when WB matches, otherwise 0.
- Strobes are combinational and valid in the same cycle as their causes; the pipeline registers act on the following edge. Latency from a hazard to its bubble is zero cycles.
- Counters saturate at all-ones and never wrap.
- Reset (rst=0, asynchronous):
  - all entries invalid;
  - counters 0;
  - hence fwd_sel=0, stall_if_id=0, all flushes 0 while reset is held and at the first clock after release.
- Reset mid-stall: the pending stall is discarded; after release, ID re-presents its instruction with no scoreboard history.
- Simultaneous br_taken and lu: flush wins. The stall is dropped and stall_cnt is not incremented.

Test Plan:
- Reset: hold rst=0 for 3 cycles, drive id_valid=1 → all strobes 0, fwd_sel=0, counters 0; after release stall_cnt stays 0 until a real hazard.
- Back-to-back ALU: ADD r3 then SUB r4,r3,r3 (NREAD=2) → when SUB is in EX, fwd_sel={1,1}; no stall.
- Gap of one: ADD r3, NOP, OR r5,r3,r0 → OR in EX gives fwd_sel port0=2, port1=0 (r0 is never forwarded).
- Load-use: LW r7 then ADD r8,r7,r1 → stall_if_id=1 and id_ex_flush=1 for exactly 1 cycle, stall_cnt=1; ADD in EX next-next cycle with port0 fwd_sel=2.
- Branch, BR_STAGE=3: br_taken for 1 cycle → if_id_flush=id_ex_flush=ex_mem_flush=1, flush_cnt=1, MEM entry invalid next cycle. Same with BR_STAGE=2 → ex_mem_flush=0.
- Freeze and saturation: ext_stall=1 concurrent with lu and br_taken → all strobes 0, scoreboard and counters unchanged. CNT_W=2 with 5 load-use stalls → stall_cnt=3.
